// File: rtl/score_timer_bcd.sv
// Game-state digit source: 4-digit BCD score, BCD MM:SS countdown timer,
// and an IDLE/RUN/OVER state machine. All outputs are registered and show the
// values committed at the previous edge, selected by sel.
module score_timer_bcd #(
  parameter logic [3:0] START_MT = 4'd0,
  parameter logic [3:0] START_MO = 4'd1,
  parameter logic [3:0] START_ST = 4'd0,
  parameter logic [3:0] START_SO = 4'd0,
  parameter logic [3:0] WARN_ST  = 4'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       tick_1hz,
  input  logic       sel,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic       blink,
  output logic       running,
  output logic       game_over
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  // Timer packing: [15:12] minutes tens, [11:8] minutes ones,
  // [7:4] seconds tens, [3:0] seconds ones. Score packs thousands..ones.
  localparam logic [15:0] RELOAD = {START_MT, START_MO, START_ST, START_SO};

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] digits_q, digits_d;
  logic        blink_q, blink_d;
  logic        running_q, running_d;
  logic        game_over_q, game_over_d;

  // BCD increment with ripple carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // MM:SS decrement; seconds-tens wraps to 5, every other digit to 9.
  function automatic logic [15:0] time_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    logic [3:0]  lim;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lim = (i == 1) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = lim;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    timer_d = timer_q;
    if (start) begin
      // start wins over any same-cycle hit/tick, in every state
      state_d = S_RUN;
      score_d = 16'h0000;
      timer_d = RELOAD;
    end else if (state_q == S_RUN) begin
      if (hit) score_d = bcd_inc_sat(score_q);
      if (tick_1hz) begin
        timer_d = time_dec(timer_q);
        if (timer_d == 16'h0000) state_d = S_OVER;
      end
    end

    // Outputs decode the committed (pre-edge) values, hence one clk latency
    digits_d    = sel ? timer_q : score_q;
    blink_d     = (state_q == S_OVER) ||
                  ((state_q == S_RUN) && (timer_q[15:8] == 8'h00) &&
                   (timer_q[7:4] < WARN_ST));
    running_d   = (state_q == S_RUN);
    game_over_d = (state_q == S_OVER);
  end

  // State, counters and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      score_q     <= 16'h0000;
      timer_q     <= RELOAD;
      digits_q    <= 16'h0000;
      blink_q     <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      timer_q     <= timer_d;
      digits_q    <= digits_d;
      blink_q     <= blink_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  assign digit_1   = digits_q[15:12];
  assign digit_2   = digits_q[11:8];
  assign digit_3   = digits_q[7:4];
  assign digit_4   = digits_q[3:0];
  assign blink     = blink_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_timer_bcd.sv
// Testbench for score_timer_bcd: directed steps plus a randomized phase,
// checked every cycle against an integer model (score as a number,
// timer as remaining seconds).
module tb_score_timer_bcd;

  localparam int RELOAD_SECS = 60;   // 01:00
  localparam int WARN_SECS   = 10;   // WARN_ST = 1 -> last 9 s

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, hit, tick_1hz, sel;
  logic [3:0] digit_1, digit_2, digit_3, digit_4;
  logic       blink, running, game_over;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 0 = idle, 1 = run, 2 = over
  int          m_state, m_score, m_secs;
  logic [15:0] e_dig;
  logic        e_blink, e_run, e_over;

  score_timer_bcd dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .tick_1hz(tick_1hz),
    .sel(sel), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .digit_4(digit_4), .blink(blink), .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] score_digits(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] timer_digits(input int s);
    int m;
    m = s / 60;
    return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_secs = RELOAD_SECS;
    e_dig = 16'h0000; e_blink = 1'b0; e_run = 1'b0; e_over = 1'b0;
  endtask

  task automatic check(input string tag);
    logic [15:0] dig;
    dig = {digit_1, digit_2, digit_3, digit_4};
    n_assert++;
    assert (dig === e_dig) else begin
      n_fail++; $error("FAIL %s digits got %h want %h", tag, dig, e_dig);
    end
    n_assert++;
    assert (blink === e_blink) else begin
      n_fail++; $error("FAIL %s blink got %b want %b", tag, blink, e_blink);
    end
    n_assert++;
    assert (running === e_run) else begin
      n_fail++; $error("FAIL %s running got %b want %b", tag, running, e_run);
    end
    n_assert++;
    assert (game_over === e_over) else begin
      n_fail++; $error("FAIL %s game_over got %b want %b", tag, game_over, e_over);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, check at +1.
  task automatic cycle(input bit s, input bit h, input bit t, input bit se,
                       input string tag);
    start = s; hit = h; tick_1hz = t; sel = se;
    @(posedge clk);
    e_dig   = se ? timer_digits(m_secs) : score_digits(m_score);
    e_blink = (m_state == 2) || (m_state == 1 && m_secs < WARN_SECS);
    e_run   = (m_state == 1);
    e_over  = (m_state == 2);
    if (s) begin
      m_state = 1; m_score = 0; m_secs = RELOAD_SECS;
    end else if (m_state == 1) begin
      if (h && m_score < 9999) m_score++;
      if (t) begin
        m_secs--;
        if (m_secs == 0) m_state = 2;
      end
    end
    #1;
    check(tag);
    start = 0; hit = 0; tick_1hz = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; hit = 0; tick_1hz = 0; sel = 1;
    model_reset();
    #3 check("reset");
    @(negedge clk) rst_n = 1'b1;

    // Idle after reset: timer 01:00 visible, hit/tick ignored
    cycle(0, 0, 0, 1, "post_reset");
    cycle(0, 1, 1, 1, "idle_ignore");
    cycle(1, 0, 0, 1, "start");
    cycle(0, 0, 0, 1, "start_lat");
    cycle(0, 0, 0, 1, "running");

    // Three hits shown on score
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, "hit3");
    cycle(0, 0, 0, 0, "hit3_show");

    // Timer: 01:00 -> 00:59, continue down to 00:01, warn blink region
    cycle(0, 0, 1, 1, "tick_0059");
    cycle(0, 0, 0, 1, "show_0059");
    for (int i = 0; i < 58; i++) cycle(0, 0, 1, 1, "tick_down");
    cycle(0, 0, 0, 1, "at_0001");
    // Hit coinciding with final tick is counted, then OVER
    cycle(0, 1, 1, 1, "final_hit_tick");
    cycle(0, 0, 0, 1, "over_lat");
    cycle(0, 0, 0, 0, "over_score");

    // OVER: hits and ticks frozen
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, "over_hit");
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, "over_tick");
    cycle(0, 0, 0, 0, "over_frozen");

    // Restart from OVER
    cycle(1, 1, 1, 1, "restart");
    cycle(0, 0, 0, 1, "restart_lat");
    cycle(0, 0, 0, 0, "restart_score");

    // Carry 0999 -> 1000
    for (int i = 0; i < 999; i++) cycle(0, 1, 0, 0, "to_0999");
    cycle(0, 1, 0, 0, "carry_1000");
    cycle(0, 0, 0, 0, "show_1000");

    // start + hit in RUN: hit discarded
    cycle(1, 1, 0, 0, "start_hit");
    cycle(0, 0, 0, 0, "start_hit_lat");
    cycle(0, 0, 0, 0, "start_hit_show");

    // Randomized play
    for (int i = 0; i < 2500; i++)
      cycle(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, "random");

    // Saturation at 9999
    cycle(1, 0, 0, 0, "sat_start");
    for (int i = 0; i < 9999; i++) cycle(0, 1, 0, 0, "to_9999");
    cycle(0, 1, 0, 0, "sat_hit");
    cycle(0, 1, 0, 0, "sat_hold");
    cycle(0, 0, 0, 0, "sat_show");

    // Asynchronous reset mid-RUN, between edges
    cycle(0, 0, 1, 1, "pre_reset");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset");
    @(negedge clk) rst_n = 1'b1;
    cycle(0, 0, 0, 1, "rel_1");
    cycle(0, 1, 1, 1, "rel_idle");
    cycle(0, 0, 0, 1, "rel_idle2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
